// File: rtl/filter_channel_arbiter.sv
// Round-robin arbiter that time-shares one FIR filter between NumCh sample streams.
// Exactly one sample is in flight: grant -> issue to filter -> wait for result -> deliver.
module filter_channel_arbiter #(
  parameter int NumCh     = 2,
  parameter int DataWidth = 18
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumCh-1:0]               ch_en_i,
  input  logic [NumCh*(DataWidth+1)-1:0] ch_in_data_i,
  input  logic [NumCh-1:0]               ch_in_req_i,
  output logic [NumCh-1:0]               ch_in_ack_o,
  output logic [DataWidth:0]             ch_out_data_o,
  output logic [NumCh-1:0]               ch_out_req_o,
  input  logic [NumCh-1:0]               ch_out_ack_i,
  output logic [DataWidth:0]             flt_in_data_o,
  output logic                           flt_in_req_o,
  input  logic                           flt_in_ack_i,
  input  logic [DataWidth:0]             flt_out_data_i,
  input  logic                           flt_out_req_i,
  output logic                           flt_out_ack_o,
  output logic                           busy_o,
  output logic [$clog2(NumCh)-1:0]       cur_ch_o
);

  localparam int ChIdxWidth = $clog2(NumCh);
  localparam int SW         = DataWidth + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  localparam logic [ChIdxWidth-1:0] LastCh = ChIdxWidth'(NumCh - 1);
  localparam logic [NumCh-1:0]      OneHot = NumCh'(1);

  logic [1:0]            r_state, w_state_nxt;
  logic [ChIdxWidth-1:0] r_ptr, r_cur_ch, w_grant, w_ptr_nxt;
  logic [DataWidth:0]    r_sample, r_result, w_grant_data;
  logic [NumCh-1:0]      w_eligible;
  logic                  w_any;
  logic                  w_grant_fire, w_flt_in_fire, w_flt_out_fire, w_deliver_fire;

  // Reset gates eligibility so the combinational input ack is also 0 while in reset.
  assign w_eligible = ch_in_req_i & ch_en_i & {NumCh{rst_ni}};

  // First eligible channel at or after r_ptr, wrapping below NumCh.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    logic [ChIdxWidth-1:0] idx_v;
    idx     = 0;
    idx_v   = '0;
    w_any   = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NumCh; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NumCh) idx = idx - NumCh;
      idx_v = idx[ChIdxWidth-1:0];
      if (!w_any && w_eligible[idx_v]) begin
        w_any   = 1'b1;
        w_grant = idx_v;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (w_grant == ChIdxWidth'(k)) w_grant_data = ch_in_data_i[k*SW +: SW];
    end
  end

  assign w_grant_fire   = (r_state == ST_IDLE) && w_any;
  assign w_flt_in_fire  = (r_state == ST_ISSUE) && flt_in_ack_i;
  assign w_flt_out_fire = (r_state == ST_WAIT) && flt_out_req_i;
  assign w_deliver_fire = (r_state == ST_DELIVER) && ch_out_ack_i[r_cur_ch];
  assign w_ptr_nxt      = (r_cur_ch == LastCh) ? '0 : r_cur_ch + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant_fire)   w_state_nxt = ST_ISSUE;
      ST_ISSUE:   if (w_flt_in_fire)  w_state_nxt = ST_WAIT;
      ST_WAIT:    if (w_flt_out_fire) w_state_nxt = ST_DELIVER;
      ST_DELIVER: if (w_deliver_fire) w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cur_ch <= '0;
      r_sample <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_fire) begin
        r_sample <= w_grant_data;
        r_cur_ch <= w_grant;
      end
      if (w_flt_out_fire) r_result <= flt_out_data_i;
      if (w_deliver_fire) r_ptr <= w_ptr_nxt;
    end
  end

  assign ch_in_ack_o   = w_grant_fire ? (OneHot << w_grant) : '0;
  assign flt_in_req_o  = (r_state == ST_ISSUE);
  assign flt_in_data_o = r_sample;
  assign flt_out_ack_o = w_flt_out_fire;
  assign ch_out_req_o  = (r_state == ST_DELIVER) ? (OneHot << r_cur_ch) : '0;
  assign ch_out_data_o = r_result;
  assign busy_o        = (r_state != ST_IDLE);
  assign cur_ch_o      = r_cur_ch;

  a_in_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ch_in_ack_o));
  a_out_req_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ch_out_req_o));
  a_cur_ch_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(cur_ch_o) < NumCh);
  a_busy_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o == (r_state != ST_IDLE));

endmodule

// File: tb/tb_filter_channel_arbiter.sv
// Bench for filter_channel_arbiter (NumCh=4): filter model, channel sources/sinks,
// and a round-robin reference model driven by the arbitration rules.
module tb_filter_channel_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 18;
  localparam int SW  = DW + 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NCH-1:0]    ch_en_i, ch_in_req_i, ch_in_ack_o, ch_out_req_o, ch_out_ack_i;
  logic [NCH*SW-1:0] ch_in_data_i;
  logic [SW-1:0]     lane [NCH];
  logic [SW-1:0]     ch_out_data_o, flt_in_data_o, flt_out_data_i;
  logic              flt_in_req_o, flt_in_ack_i, flt_out_req_i, flt_out_ack_o, busy_o;
  logic [1:0]        cur_ch_o;

  assign ch_in_data_i = {lane[3], lane[2], lane[1], lane[0]};

  filter_channel_arbiter #(.NumCh(NCH), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ch_en_i(ch_en_i), .ch_in_data_i(ch_in_data_i),
    .ch_in_req_i(ch_in_req_i), .ch_in_ack_o(ch_in_ack_o), .ch_out_data_o(ch_out_data_o),
    .ch_out_req_o(ch_out_req_o), .ch_out_ack_i(ch_out_ack_i), .flt_in_data_o(flt_in_data_o),
    .flt_in_req_o(flt_in_req_o), .flt_in_ack_i(flt_in_ack_i), .flt_out_data_i(flt_out_data_i),
    .flt_out_req_i(flt_out_req_i), .flt_out_ack_o(flt_out_ack_o), .busy_o(busy_o),
    .cur_ch_o(cur_ch_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  int            g_ch[$], d_ch[$];
  logic [SW-1:0] g_dat[$], d_dat[$];
  logic [NCH-1:0] src_keep;

  // Filter transfer function: rotate left by one (19'h00123 -> 19'h00246).
  function automatic logic [SW-1:0] rot(input logic [SW-1:0] x);
    return {x[SW-2:0], x[SW-1]};
  endfunction

  function automatic int oh2idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration rule: first eligible channel searching from ptr, modulo NCH.
  function automatic int rr_pick(input int ptr, input logic [NCH-1:0] elig);
    for (int i = 0; i < NCH; i++) if (elig[(ptr + i) % NCH]) return (ptr + i) % NCH;
    return -1;
  endfunction

  // Grant monitor and channel sources.
  int gm_idx;
  initial begin
    forever begin
      @(negedge clk_i);
      if (ch_in_ack_o != '0) begin
        gm_idx = oh2idx(ch_in_ack_o);
        g_ch.push_back(gm_idx);
        g_dat.push_back(lane[gm_idx]);
        @(posedge clk_i); #1;
        if (src_keep[gm_idx]) lane[gm_idx] = SW'($urandom);
        else ch_in_req_i[gm_idx] = 1'b0;
      end
    end
  end

  // Delivery monitor and channel sinks.
  bit             sink_en;
  int             sink_dly, sink_cnt;
  logic [NCH-1:0] sink_drive;
  initial begin
    ch_out_ack_i = '0;
    sink_cnt     = 0;
    forever begin
      @(negedge clk_i);
      if ((ch_out_req_o & ch_out_ack_i) != '0) begin
        d_ch.push_back(oh2idx(ch_out_req_o & ch_out_ack_i));
        d_dat.push_back(ch_out_data_o);
      end
      sink_drive = '0;
      if (sink_en && ch_out_req_o != '0 && ch_out_ack_i == '0) begin
        if (sink_cnt >= sink_dly) begin
          sink_drive = ch_out_req_o;
          sink_cnt   = 0;
        end else sink_cnt++;
      end
      @(posedge clk_i); #1;
      if (sink_en) ch_out_ack_i = sink_drive;
    end
  end

  // Filter model: ack input after a delay, return rot(sample) after another delay.
  int            fm_phase, fm_cnt, fm_ack_dly, fm_res_dly;
  bit            fm_rand;
  logic          fm_seen_req, fm_seen_out;
  logic [SW-1:0] fm_seen_data, fm_sample;
  initial begin
    flt_in_ack_i   = 1'b0;
    flt_out_req_i  = 1'b0;
    flt_out_data_i = '0;
    fm_phase       = 0;
    fm_cnt         = 0;
    forever begin
      @(negedge clk_i);
      fm_seen_req  = flt_in_req_o;
      fm_seen_data = flt_in_data_o;
      fm_seen_out  = flt_out_req_i && flt_out_ack_o;
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        fm_phase      = 0;
        flt_in_ack_i  = 1'b0;
        flt_out_req_i = 1'b0;
      end else begin
        case (fm_phase)
          0: if (fm_seen_req) begin
               fm_cnt   = fm_rand ? int'($urandom_range(0, 4)) : fm_ack_dly - 1;
               fm_phase = 1;
             end
          1: if (fm_cnt <= 0) begin
               flt_in_ack_i = 1'b1;
               fm_sample    = fm_seen_data;
               fm_phase     = 2;
             end else fm_cnt = fm_cnt - 1;
          2: begin
               flt_in_ack_i = 1'b0;
               fm_cnt       = fm_rand ? int'($urandom_range(0, 6)) : fm_res_dly - 2;
               fm_phase     = 3;
             end
          3: if (fm_cnt <= 0) begin
               flt_out_req_i  = 1'b1;
               flt_out_data_i = rot(fm_sample);
               fm_phase       = 4;
             end else fm_cnt = fm_cnt - 1;
          default: if (fm_seen_out) begin
               flt_out_req_i  = 1'b0;
               flt_out_data_i = SW'($urandom);
               fm_phase       = 0;
             end
        endcase
      end
    end
  end

  task automatic do_reset();
    rst_ni        = 1'b0;
    ch_en_i       = '0;
    ch_in_req_i   = '0;
    src_keep      = '0;
    sink_en       = 1'b0;
    ch_out_ack_i  = '0;
    flt_out_req_i = 1'b0;
    flt_in_ack_i  = 1'b0;
    fm_rand       = 1'b0;
    fm_ack_dly    = 1;
    fm_res_dly    = 2;
    repeat (2) @(posedge clk_i);
    #1;
    g_ch.delete(); g_dat.delete(); d_ch.delete(); d_dat.delete();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [NCH*2+SW*2+5:0] outs;
    rst_ni = 1'b0;
    ch_en_i = '1;
    ch_in_req_i = '1;
    @(negedge clk_i);
    outs = {ch_in_ack_o, ch_out_req_o, ch_out_data_o, flt_in_data_o,
            flt_in_req_o, flt_out_ack_o, busy_o, cur_ch_o};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_asserted: outputs=%h expected 0", outs);
    end
    do_reset();
    @(negedge clk_i);
    outs = {ch_in_ack_o, ch_out_req_o, ch_out_data_o, flt_in_data_o,
            flt_in_req_o, flt_out_ack_o, busy_o, cur_ch_o};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_idle: outputs=%h expected 0", outs);
    end
  endtask

  task automatic test_single();
    bit found;
    int exp;
    do_reset();
    fm_ack_dly = 3;
    fm_res_dly = 130;
    sink_en    = 1'b1;
    sink_dly   = 0;
    lane[1]    = 19'h00123;
    ch_en_i    = 4'b0011;
    ch_in_req_i = 4'b0010;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk_i);
      if (ch_in_ack_o != '0) found = 1;
    end
    n_cmp++;
    if (ch_in_ack_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL single_in_ack: got %b expected 0010", ch_in_ack_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if ({ch_in_ack_o, flt_in_req_o, flt_in_data_o, cur_ch_o, busy_o} !==
        {4'b0000, 1'b1, 19'h00123, 2'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL single_issue: ack=%b req=%b data=%h cur=%0d busy=%b expected 0000 1 00123 1 1",
               ch_in_ack_o, flt_in_req_o, flt_in_data_o, cur_ch_o, busy_o);
    end
    found = 0;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk_i);
      if (ch_out_req_o != '0) found = 1;
    end
    n_cmp++;
    if (ch_out_req_o !== 4'b0010 || ch_out_data_o !== 19'h00246) begin
      n_bad++;
      $display("FAIL single_deliver: req=%b data=%h expected 0010 00246", ch_out_req_o, ch_out_data_o);
    end
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk_i);
      if (!busy_o) found = 1;
    end
    n_cmp++;
    if (d_ch.size() != 1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: deliveries=%0d busy=%b expected 1 0", d_ch.size(), busy_o);
    end
    @(posedge clk_i); #1;
    lane[0] = SW'($urandom);
    ch_in_req_i = 4'b0011;
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk_i);
      if (g_ch.size() >= 2) found = 1;
    end
    exp = rr_pick((1 + 1) % NCH, 4'b0011);
    n_cmp++;
    if (g_ch.size() < 2 || g_ch[1] != exp) begin
      n_bad++;
      $display("FAIL single_ptr: grants=%0d second=%0d expected %0d", g_ch.size(),
               (g_ch.size() >= 2) ? g_ch[1] : -1, exp);
    end
  endtask

  task automatic test_contention();
    bit found;
    int ptr, exp;
    do_reset();
    fm_rand  = 1'b1;
    sink_en  = 1'b1;
    sink_dly = int'($urandom_range(0, 3));
    for (int k = 0; k < NCH; k++) lane[k] = SW'($urandom);
    src_keep    = '1;
    ch_en_i     = '1;
    ch_in_req_i = '1;
    found = 0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge clk_i);
      if (d_ch.size() >= 8) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL contention_timeout: deliveries=%0d expected 8", d_ch.size());
    end else begin
      ptr = 0;
      for (int i = 0; i < 8; i++) begin
        exp = rr_pick(ptr, 4'b1111);
        n_cmp++;
        if (g_ch[i] != exp || d_ch[i] != exp || d_dat[i] !== rot(g_dat[i])) begin
          n_bad++;
          $display("FAIL contention_%0d: grant=%0d deliver=%0d data=%h expected ch %0d data %h",
                   i, g_ch[i], d_ch[i], d_dat[i], exp, rot(g_dat[i]));
        end
        ptr = (exp + 1) % NCH;
      end
    end
  endtask

  task automatic test_enable_mask();
    bit found;
    int ptr, exp, bad_grants;
    do_reset();
    fm_rand  = 1'b1;
    sink_en  = 1'b1;
    sink_dly = int'($urandom_range(0, 2));
    for (int k = 0; k < NCH; k++) lane[k] = SW'($urandom);
    src_keep    = '1;
    ch_en_i     = 4'b0101;
    ch_in_req_i = '1;
    found = 0;
    for (int t = 0; t < 3000 && !found; t++) begin
      @(negedge clk_i);
      if (d_ch.size() >= 6) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL mask_timeout: deliveries=%0d expected 6", d_ch.size());
    end else begin
      ptr = 0;
      for (int i = 0; i < 6; i++) begin
        exp = rr_pick(ptr, 4'b0101);
        n_cmp++;
        if (g_ch[i] != exp || d_ch[i] != exp || d_dat[i] !== rot(g_dat[i])) begin
          n_bad++;
          $display("FAIL mask_%0d: grant=%0d deliver=%0d data=%h expected ch %0d data %h",
                   i, g_ch[i], d_ch[i], d_dat[i], exp, rot(g_dat[i]));
        end
        ptr = (exp + 1) % NCH;
      end
    end
    bad_grants = 0;
    foreach (g_ch[i]) if (g_ch[i] == 1 || g_ch[i] == 3) bad_grants++;
    n_cmp++;
    if (bad_grants != 0) begin
      n_bad++;
      $display("FAIL mask_disabled_grants: got %0d expected 0", bad_grants);
    end
    do_reset();
    src_keep    = '1;
    ch_en_i     = '0;
    ch_in_req_i = '1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk_i);
      n_cmp++;
      if (ch_in_ack_o !== '0 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL all_disabled_%0d: ack=%b busy=%b expected 0000 0", t, ch_in_ack_o, busy_o);
      end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    logic [SW-1:0] exp_data;
    do_reset();
    fm_ack_dly  = 1;
    fm_res_dly  = 3;
    lane[2]     = SW'($urandom);
    ch_en_i     = '1;
    ch_in_req_i = 4'b0100;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk_i);
      if (ch_out_req_o != '0) found = 1;
    end
    exp_data = rot(lane[2]);
    n_cmp++;
    if (ch_out_req_o !== 4'b0100 || ch_out_data_o !== exp_data) begin
      n_bad++;
      $display("FAIL bp_first: req=%b data=%h expected 0100 %h", ch_out_req_o, ch_out_data_o, exp_data);
    end
    for (int t = 0; t < 20; t++) begin
      @(posedge clk_i); #1;
      ch_out_ack_i  = (t == 5) ? 4'b1011 : 4'b0000;
      flt_out_req_i = (t == 10);
      flt_in_ack_i  = (t == 10);
      if (t == 10) flt_out_data_i = SW'($urandom);
      @(negedge clk_i);
      n_cmp++;
      if (ch_out_req_o !== 4'b0100 || ch_out_data_o !== exp_data || flt_out_ack_o !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: req=%b data=%h flt_ack=%b expected 0100 %h 0",
                 t, ch_out_req_o, ch_out_data_o, flt_out_ack_o, exp_data);
      end
    end
    @(posedge clk_i); #1;
    flt_out_req_i = 1'b0;
    flt_in_ack_i  = 1'b0;
    ch_out_ack_i  = 4'b0100;
    @(posedge clk_i); #1;
    ch_out_ack_i = '0;
    @(negedge clk_i);
    n_cmp++;
    if (ch_out_req_o !== '0 || busy_o !== 1'b0 || d_ch.size() != 1) begin
      n_bad++;
      $display("FAIL bp_release: req=%b busy=%b deliveries=%0d expected 0000 0 1",
               ch_out_req_o, busy_o, d_ch.size());
    end
  endtask

  task automatic test_disable_midflight();
    bit found;
    int ptr, exp;
    do_reset();
    fm_rand  = 1'b1;
    sink_en  = 1'b1;
    sink_dly = 1;
    lane[0]  = SW'($urandom);
    lane[1]  = SW'($urandom);
    src_keep    = 4'b0011;
    ch_en_i     = '1;
    ch_in_req_i = 4'b0011;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk_i);
      if (g_ch.size() >= 1) found = 1;
    end
    @(posedge clk_i); #1;
    ch_en_i[0] = 1'b0;
    found = 0;
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge clk_i);
      if (d_ch.size() >= 4) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL dis_timeout: deliveries=%0d expected 4", d_ch.size());
    end else begin
      n_cmp++;
      if (g_ch[0] != 0 || d_ch[0] != 0 || d_dat[0] !== rot(g_dat[0])) begin
        n_bad++;
        $display("FAIL dis_inflight: grant=%0d deliver=%0d data=%h expected 0 0 %h",
                 g_ch[0], d_ch[0], d_dat[0], rot(g_dat[0]));
      end
      ptr = 1;
      for (int i = 1; i < 4; i++) begin
        exp = rr_pick(ptr, 4'b0010);
        n_cmp++;
        if (g_ch[i] != exp || d_ch[i] != exp) begin
          n_bad++;
          $display("FAIL dis_after_%0d: grant=%0d deliver=%0d expected %0d", i, g_ch[i], d_ch[i], exp);
        end
        ptr = (exp + 1) % NCH;
      end
    end
  endtask

  task automatic test_reset_wait();
    bit found;
    int exp;
    logic [NCH*2+SW*2+5:0] outs;
    do_reset();
    fm_ack_dly  = 1;
    fm_res_dly  = 60;
    sink_en     = 1'b1;
    sink_dly    = 0;
    lane[1]     = SW'($urandom);
    ch_en_i     = '1;
    ch_in_req_i = 4'b0010;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk_i);
      if (flt_in_req_o && flt_in_ack_i) found = 1;
    end
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b1 || flt_in_req_o !== 1'b0 || ch_out_req_o !== '0) begin
      n_bad++;
      $display("FAIL rw_in_wait: busy=%b flt_req=%b out_req=%b expected 1 0 0000",
               busy_o, flt_in_req_o, ch_out_req_o);
    end
    @(posedge clk_i); #1;
    rst_ni      = 1'b0;
    lane[2]     = SW'($urandom);
    lane[3]     = SW'($urandom);
    ch_in_req_i = 4'b1100;
    repeat (2) begin
      @(negedge clk_i);
      outs = {ch_in_ack_o, ch_out_req_o, ch_out_data_o, flt_in_data_o,
              flt_in_req_o, flt_out_ack_o, busy_o, cur_ch_o};
      n_cmp++;
      if (outs !== '0) begin
        n_bad++;
        $display("FAIL rw_reset_outputs: outputs=%h expected 0", outs);
      end
    end
    @(posedge clk_i); #1;
    g_ch.delete(); g_dat.delete(); d_ch.delete(); d_dat.delete();
    rst_ni = 1'b1;
    exp = rr_pick(0, 4'b1100 & ch_en_i);
    found = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk_i);
      if (d_ch.size() >= 1) found = 1;
    end
    n_cmp++;
    if (!found || g_ch[0] != exp || d_ch[0] != exp || d_dat[0] !== rot(g_dat[0])) begin
      n_bad++;
      $display("FAIL rw_first_grant: found=%0d grant=%0d deliver=%0d expected ch %0d",
               found, (g_ch.size() > 0) ? g_ch[0] : -1, (d_ch.size() > 0) ? d_ch[0] : -1, exp);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    ch_en_i     = '0;
    ch_in_req_i = '0;
    src_keep    = '0;
    sink_en     = 1'b0;
    sink_dly    = 0;
    fm_rand     = 1'b0;
    fm_ack_dly  = 1;
    fm_res_dly  = 2;
    for (int k = 0; k < NCH; k++) lane[k] = SW'($urandom);
    test_reset();
    test_single();
    test_contention();
    test_enable_mask();
    test_backpressure();
    test_disable_midflight();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
